// File: rtl/scs8hd_aoi_pkg.sv
// Shared types and default sizing for the pipelined AND-OR-INVERT block.
package scs8hd_aoi_pkg;

  // Per-lane evaluation function, captured alongside the operands.
  typedef enum logic [1:0] {
    AOI = 2'b00,  // ~((&A) | (|B))
    AO  = 2'b01,  //  (&A) | (|B)
    OAI = 2'b10,  // ~((|A) & (&B))
    OA  = 2'b11   //  (|A) & (&B)
  } aoi_mode_e;

  localparam int DEF_CHANNELS = 4;
  localparam int DEF_AND_W    = 2;
  localparam int DEF_OR_W     = 3;
  localparam int DEF_CNT_W    = 8;

endpackage

// File: rtl/scs8hd_aoi_lane.sv
// One combinational lane: reduces the A and B groups and applies the selected mode.
module scs8hd_aoi_lane
  import scs8hd_aoi_pkg::*;
#(
  parameter int AND_W = DEF_AND_W,
  parameter int OR_W  = DEF_OR_W
) (
  input  aoi_mode_e        mode,
  input  logic [AND_W-1:0] a,
  input  logic [OR_W-1:0]  b,
  output logic             y
);

  logic and_a, or_a, and_b, or_b;

  assign and_a = &a;
  assign or_a  = |a;
  assign and_b = &b;
  assign or_b  = |b;

  // Mode select over the four group reductions.
  always_comb begin
    y = 1'b0;
    case (mode)
      AOI:     y = ~(and_a | or_b);
      AO:      y =  (and_a | or_b);
      OAI:     y = ~(or_a & and_b);
      OA:      y =  (or_a & and_b);
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/scs8hd_a2111oi_pipe.sv
// Two-stage valid/ready pipeline of CHANNELS AND-OR-INVERT lanes with a
// result handshake counter. S1 holds operands+mode, S2 holds evaluated y.
// Optional macro SCS8HD_PG_CHECK_EN adds vpwr/vgnd power-good inputs; while
// power is not good the pipe is flushed, outputs forced low, count held.
module scs8hd_a2111oi_pipe
  import scs8hd_aoi_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int AND_W    = DEF_AND_W,
  parameter int OR_W     = DEF_OR_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                mode,
  input  logic [CHANNELS*AND_W-1:0] a_in,
  input  logic [CHANNELS*OR_W-1:0]  b_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS-1:0]       y_out,
  input  logic                      count_clr,
`ifdef SCS8HD_PG_CHECK_EN
  input  logic                      vpwr,
  input  logic                      vgnd,
`endif
  output logic [CNT_W-1:0]          count
);

  logic pg_good;
`ifdef SCS8HD_PG_CHECK_EN
  assign pg_good = vpwr & ~vgnd;
`else
  assign pg_good = 1'b1;
`endif

  // Stage state
  logic                           s1_full_q, s1_full_d;
  aoi_mode_e                      s1_mode_q, s1_mode_d;
  logic [CHANNELS-1:0][AND_W-1:0] s1_a_q, s1_a_d;
  logic [CHANNELS-1:0][OR_W-1:0]  s1_b_q, s1_b_d;
  logic                           s2_full_q, s2_full_d;
  logic [CHANNELS-1:0]            y_q, y_d;
  logic [CNT_W-1:0]               count_q, count_d;

  logic [CHANNELS-1:0] lane_y;
  logic emit, s2_free, s1_adv, accept;

  // Handshake network: a stage advances when the next one is empty or draining.
  assign out_valid = s2_full_q & pg_good;
  assign emit      = out_valid & out_ready;
  assign s2_free   = ~s2_full_q | emit;
  assign s1_adv    = s1_full_q & s2_free & pg_good;
  assign in_ready  = pg_good & (~s1_full_q | s1_adv);
  assign accept    = in_valid & in_ready;

  // Mask keeps y_out low the instant power goes bad, before the flush lands.
  assign y_out = y_q & {CHANNELS{pg_good}};
  assign count = count_q;

  // Lanes sit between S1 and S2.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    scs8hd_aoi_lane #(
      .AND_W(AND_W),
      .OR_W (OR_W)
    ) u_lane (
      .mode(s1_mode_q),
      .a   (s1_a_q[k]),
      .b   (s1_b_q[k]),
      .y   (lane_y[k])
    );
  end

  // Next-state: load/advance stages, flush on power loss, count handshakes.
  always_comb begin
    s1_mode_d = s1_mode_q;
    s1_a_d    = s1_a_q;
    s1_b_d    = s1_b_q;
    s1_full_d = accept | (s1_full_q & ~s1_adv);
    s2_full_d = s1_adv | (s2_full_q & ~emit);
    y_d       = s1_adv ? lane_y : y_q;
    count_d   = count_q;

    if (accept) begin
      s1_mode_d = aoi_mode_e'(mode);
      s1_a_d    = a_in;
      s1_b_d    = b_in;
    end

    if (!pg_good) begin
      s1_full_d = 1'b0;
      s2_full_d = 1'b0;
      y_d       = '0;
    end

    // Clear takes priority over a same-cycle handshake.
    if (count_clr)  count_d = '0;
    else if (emit)  count_d = count_q + CNT_W'(1);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_full_q <= 1'b0;
      s1_mode_q <= AOI;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s2_full_q <= 1'b0;
      y_q       <= '0;
      count_q   <= '0;
    end else begin
      s1_full_q <= s1_full_d;
      s1_mode_q <= s1_mode_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s2_full_q <= s2_full_d;
      y_q       <= y_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_scs8hd_a2111oi_pipe.sv
// Directed bench for scs8hd_a2111oi_pipe (CHANNELS=4, AND_W=2, OR_W=3, CNT_W=4).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_scs8hd_a2111oi_pipe;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode;
  logic [7:0]  a_in;
  logic [11:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  y_out;
  logic        count_clr;
  logic [3:0]  count;
`ifdef SCS8HD_PG_CHECK_EN
  logic        vpwr;
  logic        vgnd;
`endif

  int checks = 0;
  int errors = 0;

  scs8hd_a2111oi_pipe #(
    .CHANNELS(4), .AND_W(2), .OR_W(3), .CNT_W(4)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .a_in     (a_in),
    .b_in     (b_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y_out    (y_out),
    .count_clr(count_clr),
`ifdef SCS8HD_PG_CHECK_EN
    .vpwr     (vpwr),
    .vgnd     (vgnd),
`endif
    .count    (count)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; in_valid = 1'b0; mode = 2'b00; a_in = '0; b_in = '0;
    out_ready = 1'b1; count_clr = 1'b0;
`ifdef SCS8HD_PG_CHECK_EN
    vpwr = 1'b1; vgnd = 1'b0;
`endif
    step(); step();
    RESET = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (y_out !== 4'h0) begin errors++; $display("FAIL reset_y_out: got %h expected 0", y_out); end
    checks++; if (count !== 4'h0) begin errors++; $display("FAIL reset_count: got %h expected 0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  // Lane0 sweeps all {A2,A1,B1,C1,D1}; other lanes see zeros, so AOI gives 1 there.
  task automatic test_aoi_truth();
    logic [4:0] v;
    logic       e;
    out_ready = 1'b1;
    mode = 2'b00;
    for (int i = 0; i < 32; i++) begin
      v = 5'(i);
      e = (v[4:3] != 2'b11) && (v[2:0] == 3'b000);
      a_in = {6'b0, v[4:3]};
      b_in = {9'b0, v[2:0]};
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL truth_latency[%0d]: out_valid %b expected 0", i, out_valid); end
      step();
      checks++;
      if (out_valid !== 1'b1 || y_out !== {3'b111, e}) begin
        errors++; $display("FAIL truth[%0d]: out_valid %b y_out %h expected 1 %h", i, out_valid, y_out, {3'b111, e});
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_y [4];
    exp_y[0] = 4'h0; exp_y[1] = 4'hF; exp_y[2] = 4'hF; exp_y[3] = 4'h0;
    a_in = 8'hFF; b_in = 12'h000; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || y_out !== exp_y[c-2]) begin
          errors++; $display("FAIL b2b_mode%0d: out_valid %b y_out %h expected 1 %h", c-2, out_valid, y_out, exp_y[c-2]);
        end
      end
      if (c < 4) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", c, in_ready); end
        in_valid = 1'b1; mode = 2'(c);
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] c0;
    c0 = count;
    out_ready = 1'b0; mode = 2'b01; a_in = 8'h00;
    b_in = 12'h001; in_valid = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0: got %b expected 1", in_ready); end
    step();
    b_in = 12'h008;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b expected 1", in_ready); end
    step();
    b_in = 12'h040;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || y_out !== 4'h1) begin
        errors++; $display("FAIL bp_hold[%0d]: in_ready %b out_valid %b y_out %h expected 0 1 1", c, in_ready, out_valid, y_out);
      end
      if (c == 1) out_ready = 1'b1;
      step();
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || y_out !== 4'h2) begin errors++; $display("FAIL bp_second: out_valid %b y_out %h expected 1 2", out_valid, y_out); end
    step();
    checks++; if (out_valid !== 1'b1 || y_out !== 4'h4) begin errors++; $display("FAIL bp_third: out_valid %b y_out %h expected 1 4", out_valid, y_out); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: out_valid %b expected 0", out_valid); end
    checks++; if (count !== 4'(c0 + 4'd3)) begin errors++; $display("FAIL bp_count: got %h expected %h", count, 4'(c0 + 4'd3)); end
  endtask

  task automatic test_count();
    count_clr = 1'b1; step(); count_clr = 1'b0;
    checks++; if (count !== 4'h0) begin errors++; $display("FAIL cnt_clear: got %h expected 0", count); end
    out_ready = 1'b1; mode = 2'b00; a_in = '0; b_in = '0;
    in_valid = 1'b1;
    repeat (16) step();
    in_valid = 1'b0;
    step();
    checks++; if (count !== 4'hF) begin errors++; $display("FAIL cnt_15: got %h expected f", count); end
    step();
    checks++; if (count !== 4'h0) begin errors++; $display("FAIL cnt_wrap: got %h expected 0", count); end
    // Six bundles: after five emits the sixth is waiting in S2.
    in_valid = 1'b1;
    repeat (6) step();
    in_valid = 1'b0;
    step();
    checks++; if (count !== 4'h5 || out_valid !== 1'b1) begin errors++; $display("FAIL cnt_at5: count %h out_valid %b expected 5 1", count, out_valid); end
    count_clr = 1'b1;
    step();
    count_clr = 1'b0;
    checks++; if (count !== 4'h0) begin errors++; $display("FAIL cnt_clr_wins: got %h expected 0", count); end
    step();
    checks++; if (count !== 4'h0 || out_valid !== 1'b0) begin errors++; $display("FAIL cnt_after_clr: count %h out_valid %b expected 0 0", count, out_valid); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1; mode = 2'b01; a_in = 8'h00; b_in = 12'hFFF;
    in_valid = 1'b1; step(); in_valid = 1'b0;
    step(); step();
    checks++; if (count !== 4'h1) begin errors++; $display("FAIL rst_pre_count: got %h expected 1", count); end
    out_ready = 1'b0;
    in_valid = 1'b1; step(); step(); in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || y_out !== 4'hF) begin
      errors++; $display("FAIL rst_full: in_ready %b out_valid %b y_out %h expected 0 1 f", in_ready, out_valid, y_out);
    end
    #2 RESET = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || y_out !== 4'h0 || count !== 4'h0) begin
      errors++; $display("FAIL rst_async: out_valid %b y_out %h count %h expected 0 0 0", out_valid, y_out, count);
    end
    step();
    RESET = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (out_valid !== 1'b0 || count !== 4'h0) begin
        errors++; $display("FAIL rst_stale[%0d]: out_valid %b count %h expected 0 0", c, out_valid, count);
      end
    end
  endtask

`ifdef SCS8HD_PG_CHECK_EN
  task automatic test_pg();
    logic [3:0] c0;
    out_ready = 1'b1; mode = 2'b01; a_in = 8'h00; b_in = 12'hFFF;
    in_valid = 1'b1;
    repeat (4) step();
    c0 = count;
    vgnd = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || y_out !== 4'h0) begin
      errors++; $display("FAIL pg_drop: in_ready %b out_valid %b y_out %h expected 0 0 0", in_ready, out_valid, y_out);
    end
    step(); step();
    checks++; if (count !== c0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL pg_hold: count %h out_valid %b expected %h 0", count, out_valid, c0);
    end
    vgnd = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pg_restore_ready: got %b expected 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pg_flushed: out_valid %b expected 0", out_valid); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || y_out !== 4'hF || count !== c0) begin
      errors++; $display("FAIL pg_resume: out_valid %b y_out %h count %h expected 1 f %h", out_valid, y_out, count, c0);
    end
    step();
    checks++; if (count !== 4'(c0 + 4'd1)) begin errors++; $display("FAIL pg_count: got %h expected %h", count, 4'(c0 + 4'd1)); end
    repeat (3) step();
  endtask
`endif

  initial begin
    test_reset();
    test_aoi_truth();
    test_back_to_back();
    test_backpressure();
    test_count();
    test_reset_midstream();
`ifdef SCS8HD_PG_CHECK_EN
    test_pg();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
